// File: rtl/alu_multicycle.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Multi-cycle ALU placed between decode and writeback. It uses the same opcode
// map and flags as the single-cycle 32-bit ALU, and adds the following:
//   * registered result and flags
//   * a valid/ready handshake on both the issue side and the result side
//   * an iterative signed shift-add multiplier (WIDTH steps)
//   * an optional signed restoring divider, built only when ALU_MC_DIV_EN is
//     defined. When it is not defined, opcode 00111 is treated as unknown and
//     div_by_zero is tied to 0.
//
// Opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA,
//          00110 MUL, 00111 DIV (ALU_MC_DIV_EN only). Any other opcode gives
//          result 0 with all flags 0.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   data_operandA/B [WIDTH]      operands, captured on accept
//   ctrl_ALUopcode [5]           operation select
//   ctrl_shiftamt [SHAMT_W]      shift amount for SLL/SRA
//   ctrl_valid / ctrl_ready      issue handshake (accept = valid && ready)
//   data_result [WIDTH]          registered result
//   isNotEqual, isLessThan       registered A!=B and signed A<B
//   overflow, div_by_zero        registered signed overflow and divide-by-zero
//   result_valid / result_ready  result handshake
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               div_by_zero,
    output logic               result_valid,
    input  logic               result_ready
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
`ifdef ALU_MC_DIV_EN
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif
    // The counter has to hold the value WIDTH itself, so it is one bit wider
    // than the shift amount.
    localparam int CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_reg, state_next;

    logic accept;
    logic op_iter_in;

    // ---------------------------------------------------------------- handshake
    // Gating with reset keeps every output at 0 while reset is held.
    assign ctrl_ready   = ~reset & ((state_reg == S_IDLE) |
                                    ((state_reg == S_DONE) & result_ready));
    assign accept       = ctrl_valid & ctrl_ready;
    assign result_valid = (state_reg == S_DONE);

`ifdef ALU_MC_DIV_EN
    assign op_iter_in = (ctrl_ALUopcode == OP_MUL) | (ctrl_ALUopcode == OP_DIV);
`else
    assign op_iter_in = (ctrl_ALUopcode == OP_MUL);
`endif

    // ------------------------------------------------- single-cycle datapath
    logic [WIDTH-1:0] sum_in, diff_in, sc_result;
    logic             add_ovf_in, sub_ovf_in, sc_ne, sc_lt, sc_ovf;

    always_comb begin
        sum_in     = data_operandA + data_operandB;
        diff_in    = data_operandA - data_operandB;
        add_ovf_in = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                     (sum_in[WIDTH-1] != data_operandA[WIDTH-1]);
        sub_ovf_in = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                     (diff_in[WIDTH-1] != data_operandA[WIDTH-1]);
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_ne      = (data_operandA != data_operandB);
        // XOR with the subtract overflow gives the true sign, which keeps the
        // compare correct at the signed extremes.
        sc_lt      = diff_in[WIDTH-1] ^ sub_ovf_in;
        case (ctrl_ALUopcode)
            OP_ADD: begin sc_result = sum_in;  sc_ovf = add_ovf_in; end
            OP_SUB: begin sc_result = diff_in; sc_ovf = sub_ovf_in; end
            OP_AND: sc_result = data_operandA & data_operandB;
            OP_OR:  sc_result = data_operandA | data_operandB;
            OP_SLL: sc_result = data_operandA << ctrl_shiftamt;
            OP_SRA: sc_result = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
            default: begin
                sc_ne = 1'b0;
                sc_lt = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------- iterative datapath
    // hi_reg:lo_reg is the double-width product accumulator (MUL), or the
    // remainder:quotient pair (DIV). mag_reg holds the operand magnitude that
    // is added (MUL) or subtracted (DIV) on each step.
    logic [WIDTH-1:0] a_reg, b_reg, mag_reg, hi_reg, lo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_step, lo_step;

    assign mag_a_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;

`ifdef ALU_MC_DIV_EN
    logic             div_sel_reg;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH:0]   rem_shift, trial;
    assign mag_b_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
`endif

    always_comb begin
        // Shift-add multiply step: add the multiplicand when the current LSB
        // of the multiplier is set, then shift the whole pair right.
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_reg} : {(WIDTH+1){1'b0}});
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // Restoring divide step. The remainder is always below the divisor
        // magnitude (at most 2^(WIDTH-1)), so it fits in WIDTH bits.
        rem_shift = {hi_reg, lo_reg[WIDTH-1]};
        trial     = rem_shift - {1'b0, mag_reg};
        if (div_sel_reg) begin
            if (!trial[WIDTH]) begin
                hi_step = trial[WIDTH-1:0];
                lo_step = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = rem_shift[WIDTH-1:0];
                lo_step = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Final sign correction and flags, taken from the captured operands.
    logic [WIDTH-1:0]   fin_diff, fin_result;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic               fin_sub_ovf, fin_ne, fin_lt, fin_ovf, fin_dbz, res_neg;

    always_comb begin
        fin_diff    = a_reg - b_reg;
        fin_sub_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                      (fin_diff[WIDTH-1] != a_reg[WIDTH-1]);
        fin_ne      = (a_reg != b_reg);
        fin_lt      = fin_diff[WIDTH-1] ^ fin_sub_ovf;
        res_neg     = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
        prod_mag    = {hi_reg, lo_reg};
        prod_signed = res_neg ? (~prod_mag + 1'b1) : prod_mag;
        fin_result  = prod_signed[WIDTH-1:0];
        // The product fits in WIDTH bits only if bits [2W-1:W-1] are a pure
        // sign extension.
        fin_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) ||
                        !(|prod_signed[2*WIDTH-1:WIDTH-1]));
        fin_dbz     = 1'b0;
`ifdef ALU_MC_DIV_EN
        if (div_sel_reg) begin
            fin_ovf = (a_reg == MOST_NEG) && (b_reg == {WIDTH{1'b1}});
            if (b_reg == '0) begin
                fin_result = '0;
                fin_dbz    = 1'b1;
            end else begin
                fin_result = res_neg ? (~lo_reg + 1'b1) : lo_reg;
            end
        end
`endif
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = op_iter_in ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_reg == '0) state_next = S_DONE;
            S_DONE: begin
                if (accept)            state_next = op_iter_in ? S_BUSY : S_DONE;
                else if (result_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath state
    logic [WIDTH-1:0] result_reg;
    logic             ne_reg, lt_reg, ovf_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            mag_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            ne_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_reg   <= data_operandA;
            b_reg   <= data_operandB;
            hi_reg  <= '0;
            cnt_reg <= CNT_W'(WIDTH);
            mag_reg <= mag_a_in;
            lo_reg  <= data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
`ifdef ALU_MC_DIV_EN
            if (ctrl_ALUopcode == OP_DIV) begin
                mag_reg <= mag_b_in;
                lo_reg  <= mag_a_in;
            end
`endif
            if (!op_iter_in) begin
                result_reg <= sc_result;
                ne_reg     <= sc_ne;
                lt_reg     <= sc_lt;
                ovf_reg    <= sc_ovf;
            end
        end else if (state_reg == S_BUSY) begin
            if (cnt_reg != '0) begin
                hi_reg  <= hi_step;
                lo_reg  <= lo_step;
                cnt_reg <= cnt_reg - 1'b1;
            end else begin
                result_reg <= fin_result;
                ne_reg     <= fin_ne;
                lt_reg     <= fin_lt;
                ovf_reg    <= fin_ovf;
            end
        end
    end

`ifdef ALU_MC_DIV_EN
    logic dbz_reg;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_sel_reg <= 1'b0;
            dbz_reg     <= 1'b0;
        end else if (accept) begin
            div_sel_reg <= (ctrl_ALUopcode == OP_DIV);
            if (!op_iter_in) dbz_reg <= 1'b0;
        end else if ((state_reg == S_BUSY) && (cnt_reg == '0)) begin
            dbz_reg <= fin_dbz;
        end
    end
    assign div_by_zero = dbz_reg;
`else
    assign div_by_zero = 1'b0;
`endif

    assign data_result = result_reg;
    assign isNotEqual  = ne_reg;
    assign isLessThan  = lt_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  data_operandA, data_operandB;
    logic [4:0]    ctrl_ALUopcode;
    logic [4:0]    ctrl_shiftamt;
    logic          ctrl_valid, ctrl_ready;
    logic [W-1:0]  data_result;
    logic          isNotEqual, isLessThan, overflow, div_by_zero;
    logic          result_valid, result_ready;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .overflow(overflow),
        .div_by_zero(div_by_zero), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [4:0]   sh;
        logic [31:0]  res;
        logic         ne;
        logic         lt;
        logic         ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Present one op and let the next rising edge accept it; returns #1 after that edge.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        data_operandA  = a;
        data_operandB  = b;
        ctrl_ALUopcode = op;
        ctrl_shiftamt  = sh;
        ctrl_valid     = 1'b1;
        #1;
        check("ready_before_accept", 32'(ctrl_ready), 32'd1);
        @(posedge clock);
        #1;
        ctrl_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] res, input logic ne,
                                 input logic lt, input logic ovf, input logic dbz);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_result"}, data_result, res);
        check({tag, "_ne"}, 32'(isNotEqual), 32'(ne));
        check({tag, "_lt"}, 32'(isLessThan), 32'(lt));
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(dbz));
    endtask

    // Iterative op: expect WIDTH+1 cycles of latency with ctrl_ready low the whole time.
    task automatic run_iter(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input logic ne,
                            input logic lt, input logic ovf, input logic dbz);
        int lat;
        bit ready_bad;
        lat = 0;
        ready_bad = 0;
        do_op(op, a, b, 5'd0);
        // Scramble the inputs: the captured operands must be the ones that are used.
        data_operandA  = 32'h1234_5678;
        data_operandB  = 32'h0BAD_F00D;
        ctrl_ALUopcode = 5'b00000;
        while (!result_valid && lat < 100) begin
            if (ctrl_ready) ready_bad = 1;
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_ready_low_while_busy"}, 32'(ready_bad), 32'd0);
        check_outputs(tag, res, ne, lt, ovf, dbz);
        $display("%s: A=0x%08h B=0x%08h -> result=0x%08h ovf=%0b dbz=%0b latency=%0d",
                 tag, a, b, data_result, overflow, div_by_zero, lat);
    endtask

    initial begin
        bit seen_valid;

        vecs[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{5'b00001, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{5'b00001, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{5'b00000, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'b00000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'b00001, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{5'b00011, 32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{5'b00100, 32'h00000001, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{5'b00100, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'b00101, 32'h80000000, 32'h00000000, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{5'b01000, 32'h00000005, 32'h00000003, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{5'b11111, 32'h80000000, 32'h00000001, 5'd3,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{5'b00010, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{5'b00101, 32'hF0000000, 32'h00000000, 5'd4,  32'hFF000000, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        data_operandA = '0; data_operandB = '0;
        ctrl_ALUopcode = '0; ctrl_shiftamt = '0;
        ctrl_valid = 1'b0; result_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", data_result, 32'h0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_ready_in_reset", 32'(ctrl_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(ctrl_ready), 32'd1);
        $display("reset released: ready=%0b valid=%0b", ctrl_ready, result_valid);

        // Single-cycle table, issued back to back (one op per cycle)
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            check_outputs($sformatf("vec%0d", i), vecs[i].res, vecs[i].ne, vecs[i].lt,
                          vecs[i].ovf, 1'b0);
            $display("vec%0d op=%05b A=0x%08h B=0x%08h sh=%0d -> result=0x%08h ne=%0b lt=%0b ovf=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, data_result,
                     isNotEqual, isLessThan, overflow);
        end

        // Consumer stalls for 3 cycles while a new op waits: the outputs must hold
        result_ready   = 1'b0;
        data_operandA  = 32'h1; data_operandB = 32'h1;
        ctrl_ALUopcode = 5'b00000; ctrl_valid = 1'b1;
        #1;
        check("hold_ready_low", 32'(ctrl_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check_outputs($sformatf("hold%0d", c), 32'hFF000000, 1'b1, 1'b1, 1'b0, 1'b0);
            check("hold_ready_low", 32'(ctrl_ready), 32'd0);
            $display("hold cycle %0d: result=0x%08h valid=%0b", c, data_result, result_valid);
        end
        ctrl_valid   = 1'b0;
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        check("drain_valid", 32'(result_valid), 32'd0);
        check("drain_ready", 32'(ctrl_ready), 32'd1);

        // Multiply
        run_iter("mul_m3x7",    5'b00110, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b1, 1'b1, 1'b0, 1'b0);
        run_iter("mul_2p16sq",  5'b00110, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_iter("mul_minx1",   5'b00110, 32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_iter("mul_m1xm1",   5'b00110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_MC_DIV_EN
        run_iter("div_m7d2",    5'b00111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 1'b0);
        run_iter("div_5d0",     5'b00111, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_iter("div_mindm1",  5'b00111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_iter("div_100d7",   5'b00111, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Reset 5 cycles into a multiply: the op is discarded and no result follows
        do_op(5'b00110, 32'hFFFFFFFD, 32'h00000007, 5'd0);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_result", data_result, 32'h0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_flags", {28'h0, isNotEqual, isLessThan, overflow, div_by_zero}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_ready", 32'(ctrl_ready), 32'd1);
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (result_valid) seen_valid = 1;
        end
        check("midrst_no_valid", 32'(seen_valid), 32'd0);
        $display("reset mid-MUL: result=0x%08h valid_seen=%0b ready=%0b",
                 data_result, seen_valid, ctrl_ready);

`ifndef ALU_MC_DIV_EN
        // Without the divider, opcode 00111 is unknown: single cycle, all zero
        do_op(5'b00111, 32'h00000005, 32'h00000003, 5'd0);
        check_outputs("op7_unknown", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("op 00111 (no divider): result=0x%08h valid=%0b", data_result, result_valid);
`endif

        // Normal operation after the reset
        do_op(5'b00000, 32'h00000002, 32'h00000003, 5'd0);
        check_outputs("post_rst_add", 32'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        $display("post-reset ADD 2+3 -> result=0x%08h", data_result);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
